param_ram: RTL

PARAM_RAM -- requirements
Module: param_ram

---
 rtl/param_ram.sv | 113 +++++++++++
 1 files changed

// File: rtl/param_ram.sv
// param_ram: parameterised RAM with registered read and a full-array zero sweep.
// Define RAM_BYPASS_EN for write-first behaviour on same-address read/write collisions.
module param_ram #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              clr,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [WIDTH-1:0]  out_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_wa_d;
    logic [WIDTH-1:0]  mem_wd_d;
    logic [WIDTH-1:0]  rd_data_d;

    // The sweep owns the write port; user writes only land in IDLE without clr.
    always_comb begin
        mem_we_d = 1'b0;
        mem_wa_d = wr_addr;
        mem_wd_d = in;
        if (rst_n) begin
            if (state_q == CLEAR) begin
                mem_we_d = 1'b1;
                mem_wa_d = cnt_q;
                mem_wd_d = '0;
            end else if (!clr) begin
                mem_we_d = load;
            end
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
`ifdef RAM_BYPASS_EN
        if (load && (rd_addr == wr_addr)) begin
            rd_data_d = in;
        end
`else
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem[mem_wa_d] <= mem_wd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    out_valid_q <= 1'b0;
                    // Last address written this edge: leave without wrapping.
                    if (&cnt_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (clr) begin
                        state_q     <= CLEAR;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                    end else begin
                        out_valid_q <= rd_en;
                        if (rd_en) begin
                            out_q <= rd_data_d;
                        end
                    end
                end
            endcase
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
